// File: rtl/frame_axis_bridge.sv
// frame_axis_bridge: buffers frame-readout samples into an AXI-Stream with tlast per frame,
// truncating frames cleanly on FIFO overflow or address discontinuity.
module frame_axis_bridge #(
   parameter int DATA_SIZE   = 12,
   parameter int LENGTH      = 32768,
   parameter int LENGTH_SIZE = 15,
   parameter int FIFO_DEPTH  = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            clr_stat,
   input  logic [DATA_SIZE-1:0]            FramData,
   input  logic [LENGTH_SIZE-1:0]          FramAdd,
   input  logic                            FramEn,
   output logic [31:0]                     m_axis_tdata,
   output logic [3:0]                      m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [15:0]                     frame_cnt,
   output logic [15:0]                     drop_cnt,
   output logic                            seq_err,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LENGTH_SIZE-1:0] LAST = LENGTH_SIZE'(LENGTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

   state_t                 state;
   logic [DATA_SIZE-1:0]   data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  last_mem;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            count;
   logic [LENGTH_SIZE-1:0] expected;
   logic                   empty, full, pop, can_push, is_last, in_seq, push, drop, trunc;

   assign empty    = count == '0;
   assign full     = count == (AW+1)'(FIFO_DEPTH);
   assign pop      = !empty && m_axis_tready;
   assign can_push = !full || pop;
   assign is_last  = FramAdd == LAST;
   assign in_seq   = FramAdd == expected;
   assign push     = FramEn && can_push &&
                     (state == IDLE ? enable && FramAdd == '0 : state == RUN && in_seq);
   assign drop     = FramEn && !push;
   // A refused in-frame sample closes the frame on the newest resident entry.
   assign trunc    = FramEn && state == RUN && !push && !empty;

   assign m_axis_tdata  = 32'(data_mem[rd_ptr]);
   assign m_axis_tlast  = last_mem[rd_ptr];
   assign m_axis_tvalid = !empty;
   assign m_axis_tkeep  = 4'hF;
   assign fifo_level    = count;
   assign busy          = state != IDLE || !empty;

   always_ff @(posedge clk)
      if (push) data_mem[wr_ptr] <= FramData;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         expected  <= '0;
         last_mem  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
         seq_err   <= 1'b0;
      end else begin
         if (push) begin
            state    <= is_last ? IDLE : RUN;
            expected <= FramAdd + LENGTH_SIZE'(1);
         end else if (state == RUN && FramEn)
            state <= in_seq ? DROP : IDLE;
         else if (state == DROP && FramEn && is_last)
            state <= IDLE;
         if (push) begin
            last_mem[wr_ptr] <= is_last;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (trunc) last_mem[wr_ptr - AW'(1)] <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count     <= count + (AW+1)'(push) - (AW+1)'(pop);
         frame_cnt <= clr_stat ? 16'h0 : frame_cnt + 16'(pop && m_axis_tlast);
         drop_cnt  <= clr_stat ? 16'h0 : drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
         seq_err   <= clr_stat ? 1'b0 : seq_err | (state == RUN && FramEn && !in_seq);
      end
   end
endmodule

// File: tb/tb_frame_axis_bridge.sv
// tb_frame_axis_bridge: directed and random stimulus against a queue-based frame model.
module tb_frame_axis_bridge;
   logic        clk = 0, rst = 1, enable = 0, clr_stat = 0, FramEn = 0, m_axis_tready = 0;
   logic [11:0] FramData = '0;
   logic [2:0]  FramAdd = '0;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast, m_axis_tvalid, seq_err, busy;
   logic [15:0] frame_cnt, drop_cnt;
   logic [2:0]  fifo_level;

   int errors = 0, checks = 0;

   // reference model: queue of {last, data}, frame mode 0=idle 1=run 2=drop
   logic [12:0] q[$];
   int          mode = 0, expn = 0, fcnt = 0, dcnt = 0;
   bit          serr = 0;

   frame_axis_bridge #(.DATA_SIZE(12), .LENGTH(8), .LENGTH_SIZE(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr_stat(clr_stat),
      .FramData(FramData), .FramAdd(FramAdd), .FramEn(FramEn),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .seq_err(seq_err),
      .fifo_level(fifo_level), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
      chk("tkeep", 32'(m_axis_tkeep), 32'hF);
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
      chk("drop_cnt", 32'(drop_cnt), 32'(dcnt));
      chk("seq_err", 32'(seq_err), 32'(serr));
      chk("busy", 32'(busy), 32'(mode != 0 || q.size() != 0));
      if (q.size() != 0) begin
         chk("tdata", m_axis_tdata, 32'(q[0][11:0]));
         chk("tlast", 32'(m_axis_tlast), 32'(q[0][12]));
      end
   endtask

   task automatic model_edge();
      int          n = q.size();
      bit          popm = n > 0 && m_axis_tready;
      bit          plast = popm && q[0][12];
      bit          lastp = FramAdd == 3'd7;
      bit          room = n < 4 || popm;
      bit          pushm = 0, dropm = 0, serr_set = 0;
      logic [12:0] tmp;
      if (rst) begin
         q.delete();
         mode = 0; fcnt = 0; dcnt = 0; serr = 0;
         return;
      end
      if (FramEn) begin
         if (mode == 0) begin
            if (enable && FramAdd == 0 && room) begin
               pushm = 1; mode = lastp ? 0 : 1; expn = 1;
            end else dropm = 1;
         end else if (mode == 1) begin
            if (int'(FramAdd) == expn && room) begin
               pushm = 1;
               if (lastp) mode = 0; else expn++;
            end else begin
               dropm = 1;
               if (n > 0) begin
                  tmp = q[n-1]; tmp[12] = 1'b1; q[n-1] = tmp;
               end
               if (int'(FramAdd) == expn) mode = 2;
               else begin serr_set = 1; mode = 0; end
            end
         end else begin
            dropm = 1;
            if (lastp) mode = 0;
         end
      end
      if (popm) void'(q.pop_front());
      if (pushm) q.push_back({lastp, FramData});
      fcnt = clr_stat ? 0 : (fcnt + int'(plast)) % 65536;
      dcnt = clr_stat ? 0 : (dcnt < 65535 ? dcnt + int'(dropm) : dcnt);
      serr = clr_stat ? 0 : (serr | serr_set);
   endtask

   task automatic cycle();
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
      rst = 0;
      clr_stat = 0;
   endtask

   task automatic step(input logic fen, input int a, input logic tr);
      FramEn = fen;
      FramAdd = 3'(a);
      FramData = 12'($urandom);
      m_axis_tready = tr;
      cycle();
   endtask

   task automatic frame(input int first, input int last, input logic tr);
      for (int a = first; a <= last; a++) step(1, a, tr);
   endtask

   task automatic idle(input int n, input logic tr);
      for (int i = 0; i < n; i++) step(0, 0, tr);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      enable = 1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tkeep", 32'(m_axis_tkeep), 32'hF);

      // clean frame with tready high
      frame(0, 7, 1);
      idle(3, 1);
      chk("f1_frames", 32'(frame_cnt), 1);
      chk("f1_drops", 32'(drop_cnt), 0);

      // overflow with tready low: 4 stored, 4 dropped, then drain
      frame(0, 7, 0);
      chk("ovf_level", 32'(fifo_level), 4);
      chk("ovf_drops", 32'(drop_cnt), 4);
      idle(6, 1);
      chk("ovf_frames", 32'(frame_cnt), 2);

      // full FIFO with simultaneous pop accepts the push
      frame(0, 3, 0);
      step(1, 4, 1);
      chk("fullpop_level", 32'(fifo_level), 4);
      chk("fullpop_drops", 32'(drop_cnt), 4);
      frame(5, 7, 1);
      idle(6, 1);
      chk("fullpop_frames", 32'(frame_cnt), 3);

      // address jump truncates at sample 2
      clr_stat = 1;
      idle(1, 1);
      step(1, 0, 0); step(1, 1, 0); step(1, 2, 0); step(1, 5, 0);
      chk("jump_seq", 32'(seq_err), 1);
      chk("jump_drops", 32'(drop_cnt), 1);
      idle(4, 1);
      chk("jump_frames", 32'(frame_cnt), 1);
      chk("jump_busy", 32'(busy), 0);
      frame(0, 7, 1);
      idle(3, 1);
      chk("after_jump_frames", 32'(frame_cnt), 2);

      // disabled frame and a frame joined mid-way are dropped
      clr_stat = 1;
      idle(1, 1);
      enable = 0;
      frame(0, 7, 1);
      chk("dis_drops", 32'(drop_cnt), 8);
      enable = 1;
      frame(3, 7, 1);
      chk("mid_drops", 32'(drop_cnt), 13);
      frame(0, 7, 1);
      idle(3, 1);
      chk("mid_frames", 32'(frame_cnt), 1);

      // reset in mid-frame
      frame(0, 3, 0);
      rst = 1;
      idle(1, 0);
      chk("mrst_tvalid", 32'(m_axis_tvalid), 0);
      chk("mrst_level", 32'(fifo_level), 0);
      chk("mrst_frames", 32'(frame_cnt), 0);
      chk("mrst_drops", 32'(drop_cnt), 0);

      // clr_stat wins over a same-cycle tlast pop
      frame(0, 7, 1);
      idle(2, 1);
      chk("pre_clr_frames", 32'(frame_cnt), 1);
      frame(0, 7, 1);
      clr_stat = 1;
      idle(1, 1);
      chk("clr_frames", 32'(frame_cnt), 0);
      idle(2, 1);

      // random traffic with occasional jumps, stalls, clears and resets
      begin
         int src = 0;
         for (int i = 0; i < 600; i++) begin
            int a;
            logic fen;
            fen = $urandom_range(0, 3) != 0;
            a = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : src;
            if (fen) src = (a + 1) % 8;
            enable = $urandom_range(0, 15) != 0;
            clr_stat = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 249) == 0;
            step(fen, a, $urandom_range(0, 3) != 0);
         end
      end
      enable = 1;
      idle(8, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
